conv_stride_decoder: RTL and testbench

- Sits directly downstream of the stride instruction generator.
- Accepts one stride instruction per output pixel (feature/kernel base, chin, chout, kernel h/w, bias/relu, writeback base and channel offset).
- Expands it into a stream of feature-RAM/kernel-RAM read-address beats for the MAC array, with first/last accumulation markers and per-output-channel writeback address and sideband.

---
 rtl/conv_stride_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_conv_stride_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stride_decoder.sv
// Expands one stride instruction (one output pixel) into feature/kernel read-address beats
// for the MAC array, with first/last accumulation markers and per-output-channel writeback info.
module conv_stride_decoder #(
    parameter int unsigned FRAM_AW = 12,
    parameter int unsigned KRAM_AW = 12,
    parameter int unsigned DW      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    output logic               decoder_ready,
    input  logic [FRAM_AW-1:0] stride_feature_baseaddr,
    input  logic [KRAM_AW-1:0] stride_kernel_baseaddr,
    input  logic [DW-1:0]      stride_feature_chin,
    input  logic [DW-1:0]      stride_feature_chout,
    input  logic [DW-1:0]      stride_feature_width,
    input  logic [DW-1:0]      stride_feature_height,
    input  logic [DW-1:0]      stride_kernel_sizeh,
    input  logic [DW-1:0]      stride_kernel_sizew,
    input  logic               stride_has_bias,
    input  logic               stride_has_relu,
    input  logic [FRAM_AW-1:0] stride_wb_baseaddr,
    input  logic [DW-1:0]      stride_wb_ch_offset,
    output logic               mac_valid,
    input  logic               mac_ready,
    output logic [FRAM_AW-1:0] mac_feat_addr,
    output logic [KRAM_AW-1:0] mac_kern_addr,
    output logic               mac_first,
    output logic               mac_last,
    output logic [DW-1:0]      mac_co,
    output logic [FRAM_AW-1:0] mac_wb_addr,
    output logic               mac_has_bias,
    output logic               mac_has_relu,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched instruction fields
    logic [FRAM_AW-1:0] fbase_q, fbase_d;
    logic [KRAM_AW-1:0] kbase_q, kbase_d;
    logic [FRAM_AW-1:0] wb_base_q, wb_base_d;
    logic [DW-1:0]      chin_q, chin_d, chout_q, chout_d;
    logic [DW-1:0]      width_q, width_d, height_q, height_d;
    logic [DW-1:0]      kh_q, kh_d, kw_q, kw_d;
    logic [DW-1:0]      wb_off_q, wb_off_d;
    logic [FRAM_AW-1:0] ch_stride_q, ch_stride_d;

    // Loop counters and address pointers; the pointers double as the beat outputs
    logic [DW-1:0]      co_q, co_d, ci_q, ci_d, ky_q, ky_d, kx_q, kx_d;
    logic [FRAM_AW-1:0] feat_q, feat_d, row_q, row_d, ch_q, ch_d;
    logic [KRAM_AW-1:0] kern_q, kern_d;
    logic [FRAM_AW-1:0] wb_q, wb_d;

    logic valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic bias_q, bias_d, relu_q, relu_d, ready_q, ready_d, busy_q, busy_d;

    logic kx_last, ky_last, ci_last, co_last, zero_dim;

    assign kx_last  = (kx_q == kw_q - DW'(1));
    assign ky_last  = (ky_q == kh_q - DW'(1));
    assign ci_last  = (ci_q == chin_q - DW'(1));
    assign co_last  = (co_q == chout_q - DW'(1));
    assign zero_dim = (chin_q == '0) || (chout_q == '0) || (kh_q == '0) || (kw_q == '0);

    // Next-state, loop advance and beat generation
    always_comb begin
        state_d     = state_q;
        fbase_d     = fbase_q;
        kbase_d     = kbase_q;
        wb_base_d   = wb_base_q;
        chin_d      = chin_q;
        chout_d     = chout_q;
        width_d     = width_q;
        height_d    = height_q;
        kh_d        = kh_q;
        kw_d        = kw_q;
        wb_off_d    = wb_off_q;
        ch_stride_d = ch_stride_q;
        co_d        = co_q;
        ci_d        = ci_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        feat_d      = feat_q;
        row_d       = row_q;
        ch_d        = ch_q;
        kern_d      = kern_q;
        wb_d        = wb_q;
        valid_d     = valid_q;
        first_d     = first_q;
        last_d      = last_q;
        bias_d      = bias_q;
        relu_d      = relu_q;

        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    fbase_d   = stride_feature_baseaddr;
                    kbase_d   = stride_kernel_baseaddr;
                    wb_base_d = stride_wb_baseaddr;
                    chin_d    = stride_feature_chin;
                    chout_d   = stride_feature_chout;
                    width_d   = stride_feature_width;
                    height_d  = stride_feature_height;
                    kh_d      = stride_kernel_sizeh;
                    kw_d      = stride_kernel_sizew;
                    wb_off_d  = stride_wb_ch_offset;
                    bias_d    = stride_has_bias;
                    relu_d    = stride_has_relu;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                ch_stride_d = FRAM_AW'(width_q * height_q);
                feat_d      = fbase_q;
                row_d       = fbase_q;
                ch_d        = fbase_q;
                kern_d      = kbase_q;
                wb_d        = wb_base_q;
                co_d        = '0;
                ci_d        = '0;
                ky_d        = '0;
                kx_d        = '0;
                if (zero_dim) begin
                    state_d = IDLE;
                end else begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end
            end
            ISSUE: begin
                if (mac_ready) begin
                    kern_d = kern_q + KRAM_AW'(1);
                    if (!kx_last) begin
                        kx_d   = kx_q + DW'(1);
                        feat_d = feat_q + FRAM_AW'(1);
                    end else begin
                        kx_d = '0;
                        if (!ky_last) begin
                            ky_d   = ky_q + DW'(1);
                            row_d  = row_q + FRAM_AW'(width_q);
                            feat_d = row_q + FRAM_AW'(width_q);
                        end else begin
                            ky_d = '0;
                            if (!ci_last) begin
                                ci_d   = ci_q + DW'(1);
                                ch_d   = ch_q + ch_stride_q;
                                row_d  = ch_q + ch_stride_q;
                                feat_d = ch_q + ch_stride_q;
                            end else begin
                                ci_d   = '0;
                                ch_d   = fbase_q;
                                row_d  = fbase_q;
                                feat_d = fbase_q;
                                if (!co_last) begin
                                    co_d = co_q + DW'(1);
                                    wb_d = wb_q + FRAM_AW'(wb_off_q);
                                end else begin
                                    state_d = IDLE;
                                    valid_d = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Markers follow the counters of the beat about to be presented
        if (state_d == ISSUE) begin
            first_d = (ci_d == '0) && (ky_d == '0) && (kx_d == '0);
            last_d  = (ci_d == chin_q - DW'(1)) && (ky_d == kh_q - DW'(1)) &&
                      (kx_d == kw_q - DW'(1));
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fbase_q     <= '0;
            kbase_q     <= '0;
            wb_base_q   <= '0;
            chin_q      <= '0;
            chout_q     <= '0;
            width_q     <= '0;
            height_q    <= '0;
            kh_q        <= '0;
            kw_q        <= '0;
            wb_off_q    <= '0;
            ch_stride_q <= '0;
            co_q        <= '0;
            ci_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            feat_q      <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            kern_q      <= '0;
            wb_q        <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            bias_q      <= 1'b0;
            relu_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fbase_q     <= fbase_d;
            kbase_q     <= kbase_d;
            wb_base_q   <= wb_base_d;
            chin_q      <= chin_d;
            chout_q     <= chout_d;
            width_q     <= width_d;
            height_q    <= height_d;
            kh_q        <= kh_d;
            kw_q        <= kw_d;
            wb_off_q    <= wb_off_d;
            ch_stride_q <= ch_stride_d;
            co_q        <= co_d;
            ci_q        <= ci_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            feat_q      <= feat_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            kern_q      <= kern_d;
            wb_q        <= wb_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign decoder_ready = ready_q;
    assign busy          = busy_q;
    assign mac_valid     = valid_q;
    assign mac_feat_addr = feat_q;
    assign mac_kern_addr = kern_q;
    assign mac_first     = first_q;
    assign mac_last      = last_q;
    assign mac_co        = co_q;
    assign mac_wb_addr   = wb_q;
    assign mac_has_bias  = bias_q;
    assign mac_has_relu  = relu_q;

endmodule

// File: tb/tb_conv_stride_decoder.sv
// Bench for conv_stride_decoder: vector table plus random instructions checked beat-by-beat
// against a nested-loop address model; hand sequences for reset abort and stall holding.
module tb_conv_stride_decoder;

    localparam int unsigned FA = 12;
    localparam int unsigned KA = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inst_valid = 1'b0;
    logic          decoder_ready;
    logic [FA-1:0] stride_feature_baseaddr = '0;
    logic [KA-1:0] stride_kernel_baseaddr = '0;
    logic [DW-1:0] stride_feature_chin = '0, stride_feature_chout = '0;
    logic [DW-1:0] stride_feature_width = '0, stride_feature_height = '0;
    logic [DW-1:0] stride_kernel_sizeh = '0, stride_kernel_sizew = '0;
    logic          stride_has_bias = 1'b0, stride_has_relu = 1'b0;
    logic [FA-1:0] stride_wb_baseaddr = '0;
    logic [DW-1:0] stride_wb_ch_offset = '0;
    logic          mac_valid;
    logic          mac_ready = 1'b1;
    logic [FA-1:0] mac_feat_addr;
    logic [KA-1:0] mac_kern_addr;
    logic          mac_first, mac_last;
    logic [DW-1:0] mac_co;
    logic [FA-1:0] mac_wb_addr;
    logic          mac_has_bias, mac_has_relu, busy;

    conv_stride_decoder #(.FRAM_AW(FA), .KRAM_AW(KA), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .stride_feature_baseaddr(stride_feature_baseaddr),
        .stride_kernel_baseaddr(stride_kernel_baseaddr),
        .stride_feature_chin(stride_feature_chin), .stride_feature_chout(stride_feature_chout),
        .stride_feature_width(stride_feature_width), .stride_feature_height(stride_feature_height),
        .stride_kernel_sizeh(stride_kernel_sizeh), .stride_kernel_sizew(stride_kernel_sizew),
        .stride_has_bias(stride_has_bias), .stride_has_relu(stride_has_relu),
        .stride_wb_baseaddr(stride_wb_baseaddr), .stride_wb_ch_offset(stride_wb_ch_offset),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_feat_addr(mac_feat_addr),
        .mac_kern_addr(mac_kern_addr), .mac_first(mac_first), .mac_last(mac_last),
        .mac_co(mac_co), .mac_wb_addr(mac_wb_addr), .mac_has_bias(mac_has_bias),
        .mac_has_relu(mac_has_relu), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fbase, kbase, width, height, chin, chout, kh, kw;
        bit bias, relu;
        int wb_base, wb_off;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   stall;          // 0: always ready, 1: low every 3rd cycle, 2: random
        int   exp_beats;
        int   exp_last_kern;
        int   exp_last_wb;
    } vec_t;

    typedef struct {
        int feat, kern;
        bit first, last;
        int co, wb;
        bit bias, relu;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    got_feat[$];
    beat_t last_got;
    int    got_beats;

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic check_beat(input string nm, input beat_t g, input beat_t e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got feat=%0d kern=%0d f=%0b l=%0b co=%0d wb=%0d b=%0b r=%0b exp feat=%0d kern=%0d f=%0b l=%0b co=%0d wb=%0d b=%0b r=%0b",
                     nm, g.feat, g.kern, g.first, g.last, g.co, g.wb, g.bias, g.relu,
                     e.feat, e.kern, e.first, e.last, e.co, e.wb, e.bias, e.relu);
        end
    endtask

    function automatic beat_t sample();
        beat_t b;
        b.feat = int'(mac_feat_addr);
        b.kern = int'(mac_kern_addr);
        b.first = mac_first;
        b.last = mac_last;
        b.co = int'(mac_co);
        b.wb = int'(mac_wb_addr);
        b.bias = mac_has_bias;
        b.relu = mac_has_relu;
        return b;
    endfunction

    // Reference: direct address formula over the four nested loops
    function automatic void build(input cfg_t c);
        int cs, idx;
        beat_t b;
        exp_q.delete();
        idx = 0;
        cs = (c.width * c.height) % 4096;
        for (int co = 0; co < c.chout; co++)
            for (int ci = 0; ci < c.chin; ci++)
                for (int ky = 0; ky < c.kh; ky++)
                    for (int kx = 0; kx < c.kw; kx++) begin
                        b.feat  = (c.fbase + ci * cs + ky * c.width + kx) % 4096;
                        b.kern  = (c.kbase + idx) % 4096;
                        b.first = (ci == 0) && (ky == 0) && (kx == 0);
                        b.last  = (ci == c.chin - 1) && (ky == c.kh - 1) && (kx == c.kw - 1);
                        b.co    = co;
                        b.wb    = (c.wb_base + co * c.wb_off) % 4096;
                        b.bias  = c.bias;
                        b.relu  = c.relu;
                        exp_q.push_back(b);
                        idx++;
                    end
    endfunction

    function automatic cfg_t mk(input int fb, input int kb, input int w, input int h,
                                input int ci, input int co, input int kh, input int kw,
                                input bit bi, input bit re, input int wbb, input int wbo);
        cfg_t c;
        c.fbase = fb; c.kbase = kb; c.width = w; c.height = h;
        c.chin = ci; c.chout = co; c.kh = kh; c.kw = kw;
        c.bias = bi; c.relu = re; c.wb_base = wbb; c.wb_off = wbo;
        return c;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        stride_feature_baseaddr = FA'(c.fbase);
        stride_kernel_baseaddr  = KA'(c.kbase);
        stride_feature_width    = DW'(c.width);
        stride_feature_height   = DW'(c.height);
        stride_feature_chin     = DW'(c.chin);
        stride_feature_chout    = DW'(c.chout);
        stride_kernel_sizeh     = DW'(c.kh);
        stride_kernel_sizew     = DW'(c.kw);
        stride_has_bias         = c.bias;
        stride_has_relu         = c.relu;
        stride_wb_baseaddr      = FA'(c.wb_base);
        stride_wb_ch_offset     = DW'(c.wb_off);
    endtask

    // Fields must be ignored once the instruction is taken
    task automatic scramble();
        drive_cfg(mk($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 9),
                     $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 4095), $urandom_range(0, 50)));
    endtask

    task automatic run_inst(input vec_t v);
        int    lat, cyc, budget;
        bit    done, seen, stalled;
        beat_t cur, held, e;
        build(v.c);
        got_feat.delete();
        got_beats = 0;
        @(negedge clk);
        cyc = 0;
        while (!decoder_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_int("ready_before_accept", int'(decoder_ready), 1);
        drive_cfg(v.c);
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        scramble();
        check_int("setup_ready", int'(decoder_ready), 0);
        check_int("setup_busy", int'(busy), 1);
        check_int("setup_valid", int'(mac_valid), 0);
        lat = 1;
        budget = 8 * v.exp_beats + 20;
        done = (exp_q.size() == 0);
        seen = 1'b0;
        stalled = 1'b0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
            case (v.stall)
                0: mac_ready = 1'b1;
                1: mac_ready = (lat % 3) != 0;
                default: mac_ready = 1'($urandom);
            endcase
            if (mac_valid) begin
                cur = sample();
                if (!seen) begin
                    check_int("first_beat_latency", lat, 2);
                    seen = 1'b1;
                end
                if (stalled) check_beat("stall_hold", cur, held);
                if (mac_ready) begin
                    e = exp_q.pop_front();
                    check_beat("beat", cur, e);
                    got_feat.push_back(cur.feat);
                    last_got = cur;
                    got_beats++;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    held = cur;
                end
            end else if (seen) begin
                checks++;
                failures++;
                $display("FAIL bubble valid dropped after %0d beats", got_beats);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout beats=%0d remaining=%0d", got_beats, exp_q.size());
        end
        @(negedge clk);
        mac_ready = 1'b1;
        check_int("end_valid", int'(mac_valid), 0);
        check_int("end_ready", int'(decoder_ready), 1);
        check_int("end_busy", int'(busy), 0);
        check_int("beat_count", got_beats, v.exp_beats);
        if (v.exp_beats > 0) begin
            check_int("last_kern", last_got.kern, v.exp_last_kern);
            check_int("last_wb", last_got.wb, v.exp_last_wb);
            check_int("last_flag", int'(last_got.last), 1);
        end
    endtask

    vec_t vecs[7];
    int   plan1_feat[9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};

    initial begin
        vec_t  v;
        cfg_t  c;
        beat_t e, cur;
        int    n, cyc, nb;

        vecs[0] = '{c: mk(100, 0, 5, 5, 1, 1, 3, 3, 0, 0, 0, 0), stall: 0,
                    exp_beats: 9, exp_last_kern: 8, exp_last_wb: 0};
        vecs[1] = '{c: mk(100, 0, 5, 5, 2, 2, 3, 3, 1, 0, 40, 9), stall: 0,
                    exp_beats: 36, exp_last_kern: 35, exp_last_wb: 49};
        vecs[2] = '{c: mk(100, 0, 5, 5, 1, 1, 3, 3, 0, 0, 0, 0), stall: 1,
                    exp_beats: 9, exp_last_kern: 8, exp_last_wb: 0};
        vecs[3] = '{c: mk(7, 20, 4, 4, 1, 4, 1, 1, 0, 1, 0, 1), stall: 0,
                    exp_beats: 4, exp_last_kern: 23, exp_last_wb: 3};
        vecs[4] = '{c: mk(100, 0, 5, 5, 0, 2, 3, 3, 0, 0, 0, 0), stall: 0,
                    exp_beats: 0, exp_last_kern: 0, exp_last_wb: 0};
        vecs[5] = '{c: mk(100, 0, 5, 5, 2, 2, 3, 0, 0, 0, 0, 0), stall: 0,
                    exp_beats: 0, exp_last_kern: 0, exp_last_wb: 0};
        vecs[6] = '{c: mk(4090, 4094, 3, 2, 2, 2, 2, 2, 1, 1, 4095, 2), stall: 2,
                    exp_beats: 16, exp_last_kern: 13, exp_last_wb: 1};

        #12;
        check_int("rst_ready", int'(decoder_ready), 1);
        check_int("rst_valid", int'(mac_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_feat", int'(mac_feat_addr), 0);
        check_int("rst_first", int'(mac_first), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_inst(vecs[i]);
            if (i == 0)
                for (int k = 0; k < 9; k++) check_int("plan1_feat", got_feat[k], plan1_feat[k]);
        end

        for (int r = 0; r < 6; r++) begin
            c = mk($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 8),
                   $urandom_range(1, 8), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(1, 3), $urandom_range(1, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 4095), $urandom_range(0, 300));
            nb = c.chout * c.chin * c.kh * c.kw;
            v = '{c: c, stall: 2, exp_beats: nb, exp_last_kern: (c.kbase + nb - 1) % 4096,
                  exp_last_wb: (c.wb_base + (c.chout - 1) * c.wb_off) % 4096};
            run_inst(v);
        end

        // Reset in the middle of an instruction, then a clean restart
        c = mk(100, 0, 5, 5, 2, 2, 3, 3, 0, 0, 40, 9);
        build(c);
        @(negedge clk);
        drive_cfg(c);
        mac_ready = 1'b1;
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mac_valid) begin
                e = exp_q.pop_front();
                cur = sample();
                check_beat("abort_pre_beat", cur, e);
                n++;
            end
        end
        @(negedge clk);
        check_int("abort_valid_before", int'(mac_valid), 1);
        rst_n = 1'b0;
        #1;
        check_int("abort_valid", int'(mac_valid), 0);
        check_int("abort_ready", int'(decoder_ready), 1);
        check_int("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{c: mk(200, 50, 5, 5, 1, 1, 3, 3, 0, 1, 10, 0), stall: 0,
              exp_beats: 9, exp_last_kern: 58, exp_last_wb: 10};
        run_inst(v);
        check_int("restart_first_feat", got_feat[0], 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
